// File: rtl/core_ram_arbiter.sv
// core_ram_arbiter: two-master Avalon-MM arbiter in front of a single-port
// on-chip RAM (registered inputs, 1-cycle read latency). Round-robin
// arbitration with a bounded number of consecutive grants per master.
// Optional build macro CORE_RAM_ARB_LOCK_EN adds m0_lock/m1_lock inputs that
// let the current owner keep the grant past MAX_HOLD while it requests.
module core_ram_arbiter #(
  parameter int ADDR_W   = 10,
  parameter int DATA_W   = 32,
  parameter int MAX_HOLD = 4
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [ADDR_W-1:0]     m0_address,
  input  logic [DATA_W/8-1:0]   m0_byteenable,
  input  logic                  m0_read,
  input  logic                  m0_write,
  input  logic [DATA_W-1:0]     m0_writedata,
  output logic                  m0_waitrequest,
  output logic [DATA_W-1:0]     m0_readdata,
  output logic                  m0_readdatavalid,
  input  logic [ADDR_W-1:0]     m1_address,
  input  logic [DATA_W/8-1:0]   m1_byteenable,
  input  logic                  m1_read,
  input  logic                  m1_write,
  input  logic [DATA_W-1:0]     m1_writedata,
  output logic                  m1_waitrequest,
  output logic [DATA_W-1:0]     m1_readdata,
  output logic                  m1_readdatavalid,
`ifdef CORE_RAM_ARB_LOCK_EN
  input  logic                  m0_lock,
  input  logic                  m1_lock,
`endif
  output logic [ADDR_W-1:0]     ram_address,
  output logic [DATA_W/8-1:0]   ram_byteenable,
  output logic                  ram_chipselect,
  output logic                  ram_write,
  output logic [DATA_W-1:0]     ram_writedata,
  output logic                  ram_clken,
  input  logic [DATA_W-1:0]     ram_readdata
);

  localparam int BE_W = DATA_W / 8;
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_OWN0 = 2'd1;
  localparam logic [1:0] ST_OWN1 = 2'd2;
  localparam logic [3:0] HOLD_LIM = 4'(MAX_HOLD);

  logic [1:0]        state;
  logic [3:0]        hcnt;
  logic              last_win;   // 0 = m0 won last, 1 = m1 won last
  logic              rd_pend;
  logic              rd_owner;

  logic              req0, req1;
  logic              lock0, lock1;
  logic              gnt_any;
  logic              gnt_sel;    // 0 = m0 granted, 1 = m1 granted
  logic              sel_write;
  logic              same_owner;
  logic [ADDR_W-1:0] sel_addr;
  logic [BE_W-1:0]   sel_be;
  logic [DATA_W-1:0] sel_wdata;

  // Last driven RAM inputs, kept stable while nobody is granted
  logic [ADDR_W-1:0] addr_hold;
  logic [BE_W-1:0]   be_hold;
  logic [DATA_W-1:0] wdata_hold;

  assign req0 = m0_read | m0_write;
  assign req1 = m1_read | m1_write;

`ifdef CORE_RAM_ARB_LOCK_EN
  assign lock0 = m0_lock;
  assign lock1 = m1_lock;
`else
  assign lock0 = 1'b0;
  assign lock1 = 1'b0;
`endif

  // Grant decision from current owner state, hold count and live requests
  always_comb begin
    gnt_any = 1'b0;
    gnt_sel = 1'b0;
    case (state)
      ST_OWN0: begin
        if (req0 && (!req1 || (hcnt < HOLD_LIM) || lock0)) begin
          gnt_any = 1'b1;
          gnt_sel = 1'b0;
        end else if (req1) begin
          gnt_any = 1'b1;
          gnt_sel = 1'b1;
        end
      end
      ST_OWN1: begin
        if (req1 && (!req0 || (hcnt < HOLD_LIM) || lock1)) begin
          gnt_any = 1'b1;
          gnt_sel = 1'b1;
        end else if (req0) begin
          gnt_any = 1'b1;
          gnt_sel = 1'b0;
        end
      end
      default: begin
        if (req0 && req1) begin
          gnt_any = 1'b1;
          gnt_sel = ~last_win;
        end else if (req0) begin
          gnt_any = 1'b1;
          gnt_sel = 1'b0;
        end else if (req1) begin
          gnt_any = 1'b1;
          gnt_sel = 1'b1;
        end
      end
    endcase
    if (!reset_n) gnt_any = 1'b0;
  end

  assign sel_write  = gnt_sel ? m1_write      : m0_write;
  assign sel_addr   = gnt_sel ? m1_address    : m0_address;
  assign sel_be     = gnt_sel ? m1_byteenable : m0_byteenable;
  assign sel_wdata  = gnt_sel ? m1_writedata  : m0_writedata;
  assign same_owner = ((state == ST_OWN0) && !gnt_sel) || ((state == ST_OWN1) && gnt_sel);

  // Ownership, hold counter, round-robin pointer and read-return tracking
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= ST_IDLE;
      hcnt     <= 4'd0;
      last_win <= 1'b1;
      rd_pend  <= 1'b0;
      rd_owner <= 1'b0;
    end else begin
      rd_pend  <= gnt_any & ~sel_write;
      rd_owner <= gnt_sel;
      if (gnt_any) begin
        state    <= gnt_sel ? ST_OWN1 : ST_OWN0;
        last_win <= gnt_sel;
        if (same_owner)
          hcnt <= (hcnt == 4'd15) ? 4'd15 : hcnt + 4'd1;
        else
          hcnt <= 4'd1;
      end else begin
        state <= ST_IDLE;
      end
    end
  end

  // Capture the granted master's address/data so the RAM inputs hold when idle
  always_ff @(posedge clk) begin
    if (gnt_any) begin
      addr_hold  <= sel_addr;
      be_hold    <= sel_be;
      wdata_hold <= sel_wdata;
    end
  end

  assign ram_address    = gnt_any ? sel_addr  : addr_hold;
  assign ram_byteenable = gnt_any ? sel_be    : be_hold;
  assign ram_writedata  = gnt_any ? sel_wdata : wdata_hold;
  assign ram_chipselect = gnt_any;
  assign ram_write      = gnt_any & sel_write;
  assign ram_clken      = 1'b1;

  assign m0_waitrequest = !reset_n || (req0 && !(gnt_any && !gnt_sel));
  assign m1_waitrequest = !reset_n || (req1 && !(gnt_any && gnt_sel));

  assign m0_readdata      = ram_readdata;
  assign m1_readdata      = ram_readdata;
  assign m0_readdatavalid = rd_pend & ~rd_owner;
  assign m1_readdatavalid = rd_pend & rd_owner;

endmodule

// File: tb/tb_core_ram_arbiter.sv
// Testbench for core_ram_arbiter: directed steps plus randomized traffic,
// checked against a rule-level reference model and a shadow memory.
module tb_core_ram_arbiter;
  localparam int AW = 10;
  localparam int DW = 32;
  localparam int BW = 4;
  localparam int MH = 4;
`ifdef CORE_RAM_ARB_LOCK_EN
  localparam bit LOCK_EN = 1'b1;
`else
  localparam bit LOCK_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset_n;
  logic [AW-1:0] m0_address, m1_address;
  logic [BW-1:0] m0_byteenable, m1_byteenable;
  logic          m0_read, m0_write, m1_read, m1_write;
  logic [DW-1:0] m0_writedata, m1_writedata;
  logic          m0_waitrequest, m1_waitrequest;
  logic [DW-1:0] m0_readdata, m1_readdata;
  logic          m0_readdatavalid, m1_readdatavalid;
  logic          m0_lock, m1_lock;
  logic [AW-1:0] ram_address;
  logic [BW-1:0] ram_byteenable;
  logic          ram_chipselect, ram_write, ram_clken;
  logic [DW-1:0] ram_writedata;
  logic [DW-1:0] ram_readdata;

  always #5 clk = ~clk;

  core_ram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_HOLD(MH)) dut (
    .clk(clk), .reset_n(reset_n),
    .m0_address(m0_address), .m0_byteenable(m0_byteenable), .m0_read(m0_read),
    .m0_write(m0_write), .m0_writedata(m0_writedata), .m0_waitrequest(m0_waitrequest),
    .m0_readdata(m0_readdata), .m0_readdatavalid(m0_readdatavalid),
    .m1_address(m1_address), .m1_byteenable(m1_byteenable), .m1_read(m1_read),
    .m1_write(m1_write), .m1_writedata(m1_writedata), .m1_waitrequest(m1_waitrequest),
    .m1_readdata(m1_readdata), .m1_readdatavalid(m1_readdatavalid),
`ifdef CORE_RAM_ARB_LOCK_EN
    .m0_lock(m0_lock), .m1_lock(m1_lock),
`endif
    .ram_address(ram_address), .ram_byteenable(ram_byteenable),
    .ram_chipselect(ram_chipselect), .ram_write(ram_write),
    .ram_writedata(ram_writedata), .ram_clken(ram_clken), .ram_readdata(ram_readdata)
  );

  // RAM: registered address/data inputs, unregistered output
  logic [DW-1:0] ram_mem [1024];
  logic [AW-1:0] ram_addr_q = '0;
  always @(posedge clk) begin
    if (ram_chipselect && ram_write)
      for (int b = 0; b < BW; b++)
        if (ram_byteenable[b]) ram_mem[ram_address][8*b +: 8] <= ram_writedata[8*b +: 8];
    ram_addr_q <= ram_address;
  end
  assign ram_readdata = ram_mem[ram_addr_q];

  // Reference model state
  logic [DW-1:0] ref_mem [1024];
  int            mo;          // current owner, -1 when nobody owns the RAM
  int            mstreak;     // consecutive grants of the current owner
  int            mlast;       // last master to win
  logic [AW-1:0] last_addr;
  bit            last_addr_ok;
  bit            ev0, ev1;
  logic [DW-1:0] erd;

  logic obs_w0, obs_w1, obs_rv0, obs_rv1;
  logic [DW-1:0] obs_rd0;

  int tests = 0;
  int failed = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Who should own the RAM this cycle according to the arbitration rules
  function automatic int predict();
    bit r0 = m0_read | m0_write;
    bit r1 = m1_read | m1_write;
    bit l0 = LOCK_EN && (m0_lock === 1'b1);
    bit l1 = LOCK_EN && (m1_lock === 1'b1);
    bit ro, rx, lo;
    if (mo < 0) begin
      if (r0 && r1) return (mlast == 1) ? 0 : 1;
      if (r0) return 0;
      if (r1) return 1;
      return -1;
    end
    ro = (mo == 0) ? r0 : r1;
    rx = (mo == 0) ? r1 : r0;
    lo = (mo == 0) ? l0 : l1;
    if (ro && (!rx || mstreak < MH || lo)) return mo;
    if (rx) return 1 - mo;
    return -1;
  endfunction

  task automatic clear_in();
    m0_read = 0; m0_write = 0; m0_address = '0; m0_byteenable = '0; m0_writedata = '0;
    m1_read = 0; m1_write = 0; m1_address = '0; m1_byteenable = '0; m1_writedata = '0;
    m0_lock = 0; m1_lock = 0;
  endtask

  task automatic drv0(input logic rd, input logic wr, input logic [AW-1:0] a,
                      input logic [BW-1:0] be, input logic [DW-1:0] d);
    m0_read = rd; m0_write = wr; m0_address = a; m0_byteenable = be; m0_writedata = d;
  endtask

  task automatic drv1(input logic rd, input logic wr, input logic [AW-1:0] a,
                      input logic [BW-1:0] be, input logic [DW-1:0] d);
    m1_read = rd; m1_write = wr; m1_address = a; m1_byteenable = be; m1_writedata = d;
  endtask

  // One clock cycle: check outputs at the falling edge, advance the model,
  // and return just after the next rising edge ready for new inputs.
  task automatic tick();
    int g;
    bit r0, r1, wr;
    logic [AW-1:0] a;
    logic [BW-1:0] be;
    logic [DW-1:0] wd;
    @(negedge clk);
    g  = predict();
    r0 = m0_read | m0_write;
    r1 = m1_read | m1_write;
    wr = (g == 1) ? m1_write : m0_write;
    a  = (g == 1) ? m1_address : m0_address;
    be = (g == 1) ? m1_byteenable : m0_byteenable;
    wd = (g == 1) ? m1_writedata : m0_writedata;
    obs_w0 = m0_waitrequest; obs_w1 = m1_waitrequest;
    obs_rv0 = m0_readdatavalid; obs_rv1 = m1_readdatavalid; obs_rd0 = m0_readdata;
    chk("wait0", m0_waitrequest, r0 && g != 0);
    chk("wait1", m1_waitrequest, r1 && g != 1);
    chk("chipselect", ram_chipselect, g >= 0);
    chk("ram_write", ram_write, g >= 0 && wr);
    if (g >= 0) begin
      chk("ram_address", 32'(ram_address), 32'(a));
      if (wr) begin
        chk("ram_writedata", ram_writedata, wd);
        chk("ram_byteenable", 32'(ram_byteenable), 32'(be));
      end
    end else if (last_addr_ok) begin
      chk("ram_address_hold", 32'(ram_address), 32'(last_addr));
    end
    chk("rdvalid0", m0_readdatavalid, ev0);
    chk("rdvalid1", m1_readdatavalid, ev1);
    if (ev0) chk("readdata0", m0_readdata, erd);
    if (ev1) chk("readdata1", m1_readdata, erd);
    ev0 = 0; ev1 = 0;
    if (g >= 0) begin
      if (wr) begin
        for (int b = 0; b < BW; b++)
          if (be[b]) ref_mem[a][8*b +: 8] = wd[8*b +: 8];
      end else begin
        erd = ref_mem[a];
        if (g == 0) ev0 = 1; else ev1 = 1;
      end
      last_addr = a; last_addr_ok = 1;
      mstreak = (g == mo) ? ((mstreak < 15) ? mstreak + 1 : 15) : 1;
      mo = g; mlast = g;
    end else begin
      mo = -1;
    end
    @(posedge clk); #1;
  endtask

  // Assert reset with both masters requesting, check the reset outputs, release
  task automatic do_reset();
    reset_n = 0;
    m0_read = 1; m1_read = 1;
    #1;
    chk("rst_wait0", m0_waitrequest, 1'b1);
    chk("rst_wait1", m1_waitrequest, 1'b1);
    chk("rst_chipselect", ram_chipselect, 1'b0);
    chk("rst_rdvalid0", m0_readdatavalid, 1'b0);
    chk("rst_rdvalid1", m1_readdatavalid, 1'b0);
    clear_in();
    mo = -1; mstreak = 0; mlast = 1; ev0 = 0; ev1 = 0;
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1;
  endtask

  initial begin
    int k0, k1;
    for (int i = 0; i < 1024; i++) begin
      ram_mem[i] = '0;
      ref_mem[i] = '0;
    end
    last_addr = '0; last_addr_ok = 0; erd = '0;
    clear_in();
    reset_n = 0;
    do_reset();

    // m0 write then read back
    drv0(0, 1, 10'h005, 4'hF, 32'hDEADBEEF); tick();
    chk("t1_write_accept", obs_w0, 1'b0);
    drv0(1, 0, 10'h005, 4'hF, 32'h0); tick();
    clear_in(); tick();
    chk("t1_rv0", obs_rv0, 1'b1);
    chk("t1_rd0", obs_rd0, 32'hDEADBEEF);
    chk("t1_rv1", obs_rv1, 1'b0);

    // Tie on first cycle after reset
    do_reset();
    drv0(1, 0, 10'h005, 4'hF, 32'h0);
    drv1(1, 0, 10'h006, 4'hF, 32'h0);
    tick();
    chk("t2_m0_first", obs_w0, 1'b0);
    chk("t2_m1_waits", obs_w1, 1'b1);
    drv0(0, 0, 10'h0, 4'h0, 32'h0);
    tick();
    chk("t2_m1_next", obs_w1, 1'b0);
    clear_in(); tick();

    // Continuous contention: four grants each, alternating
    do_reset();
    for (int i = 0; i < 16; i++) begin
      drv0(1, 0, AW'(i % 8), 4'hF, 32'h0);
      drv1(1, 0, AW'((i + 3) % 8), 4'hF, 32'h0);
      tick();
      chk("rr_wait0", obs_w0, ((i / 4) % 2) == 1);
      chk("rr_wait1", obs_w1, ((i / 4) % 2) == 0);
    end
    clear_in(); tick();

    // Byte-lane write
    drv0(0, 1, 10'h009, 4'hF, 32'h11223344); tick();
    drv0(0, 1, 10'h009, 4'h2, 32'h0000AB00); tick();
    drv0(1, 0, 10'h009, 4'hF, 32'h0); tick();
    clear_in(); tick();
    chk("byte_rv0", obs_rv0, 1'b1);
    chk("byte_rd0", obs_rd0, 32'h1122AB44);

    // Reset in the cycle after an accepted read
    drv0(1, 0, 10'h009, 4'hF, 32'h0); tick();
    do_reset();
    drv0(1, 0, 10'h001, 4'hF, 32'h0);
    drv1(1, 0, 10'h002, 4'hF, 32'h0);
    tick();
    chk("rst_tie_m0", obs_w0, 1'b0);
    chk("rst_tie_m1", obs_w1, 1'b1);
    chk("rst_no_rv0", obs_rv0, 1'b0);
    clear_in(); tick(); tick();

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      k0 = int'($urandom_range(0, 3));
      k1 = int'($urandom_range(0, 3));
      drv0(k0[0], k0[1], AW'($urandom_range(0, 7)), BW'($urandom_range(0, 15)), $urandom);
      drv1(k1[0], k1[1], AW'($urandom_range(0, 7)), BW'($urandom_range(0, 15)), $urandom);
      tick();
    end
    clear_in(); tick(); tick();

`ifdef CORE_RAM_ARB_LOCK_EN
    // Locked ownership by m1
    do_reset();
    drv1(1, 0, 10'h003, 4'hF, 32'h0); m1_lock = 1; tick();
    drv0(1, 0, 10'h004, 4'hF, 32'h0);
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("lock_m0_waits", obs_w0, 1'b1);
    end
    m1_lock = 0;
    tick();
    chk("lock_release_m0", obs_w0, 1'b0);
    clear_in(); tick();
`endif

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule

// File: doc/core_ram_arbiter.md
Name: core_ram_arbiter

Overview:
- Two-master Avalon-MM arbiter in front of one single-port 1024x32 on-chip RAM with byte enables.
- The RAM has registered address/data inputs and an unregistered output, so read latency is 1 cycle.
- Lets two Nios II cores of the multicore system share one RAM instance.
- Sits between the two core data masters and the RAM slave port; grants are round-robin with bounded hold.

Parameters:
ADDR_W, 10, word address width to RAM
DATA_W, 32, data width; byte enable width is DATA_W/8
MAX_HOLD, 4, max consecutive grants to one master while the other is waiting (range 1..15)

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
m0_address  in  ADDR_W  master 0 word address
m0_byteenable  in  DATA_W/8  master 0 byte enables
m0_read  in  1  master 0 read request
m0_write  in  1  master 0 write request
m0_writedata  in  DATA_W  master 0 write data
m0_waitrequest  out  1  master 0 stall
m0_readdata  out  DATA_W  master 0 read data
m0_readdatavalid  out  1  master 0 read data valid
m1_*  (same set as m0_*)  master 1
ram_address  out  ADDR_W  to RAM
ram_byteenable  out  DATA_W/8  to RAM
ram_chipselect  out  1  to RAM
ram_write  out  1  to RAM
ram_writedata  out  DATA_W  to RAM
ram_clken  out  1  RAM clock enable, tied 1
ram_readdata  in  DATA_W  from RAM, valid 1 cycle after read issue

Behaviour:
- Request: mX_req = mX_read | mX_write. If read and write are both asserted, the request is treated as a write.
- Arbitration FSM, registered state:
  - States: IDLE, OWN0, OWN1, plus a hold counter hcnt (4 bits) and a last-winner pointer.
  - Grant is combinational from state and the current requests.
  - IDLE: one requester wins immediately. If both request, the master not equal to last winner wins. After reset the last winner is m1, so m0 wins the first tie.
  - OWNx: x keeps the grant while mX_req=1 and (other idle or hcnt<MAX_HOLD).
  - Hold limit: when the other master requests and hcnt==MAX_HOLD, the grant passes to the other master in that same cycle, and hcnt is set to 1.
  - If x drops its request: grant goes to the other master if it is requesting, else the FSM returns to IDLE.
  - hcnt increments on every accepted transfer by the owner and saturates at 15. It is reset to 1 on an ownership change.
- Acceptance: a transfer is accepted in the cycle the master holds the grant. That master's waitrequest=0 that cycle. A non-granted master with a request sees waitrequest=1. A master with no request sees waitrequest=0.
- RAM drive: ram_* are combinational from the granted master. ram_chipselect=1 on any accepted transfer. ram_write=1 only for an accepted write. With no grant, ram_chipselect=0 and the address/data hold their last values.
- Read return:
  - Registered rd_pend (1 bit) and rd_owner.
  - The cycle after an accepted read, readdatavalid=1 to rd_owner only, and readdata=ram_readdata.
  - readdata is not gated; readdatavalid qualifies it.
  - Back-to-back reads, including alternating masters, sustain 1 accepted transfer per cycle.
- A write followed by a read to the same address on the next cycle returns the new data; the RAM port is the same, so ordering is preserved.
- Reset: asynchronous, active-low. It forces IDLE, hcnt=0, last winner=m1, rd_pend=0, and all readdatavalid=0. During reset, waitrequest=1 for both masters and ram_chipselect=0.
- Reset mid-read: the pending readdatavalid is dropped and never issued.

Optional Feature:
- Macro CORE_RAM_ARB_LOCK_EN adds inputs m0_lock and m1_lock (1 bit each).
- With the macro defined: while the owner asserts lock together with a request, the grant is held regardless of MAX_HOLD. The other master waits indefinitely. When lock deasserts, normal hold rules resume with the current hcnt.
- Without the macro: the lock ports do not exist and arbitration is purely as above.

Test Plan:
- Reset release, m0 writes 0xDEADBEEF to addr 0x005 with byteenable 0xF, then reads addr 0x005 -> write accepted in cycle 1; m0_readdatavalid=1 with 0xDEADBEEF one cycle after the read is accepted; m1 sees no valid.
- Both masters assert a read in the first cycle after reset -> m0 granted first (m1_waitrequest=1); m1 granted the next cycle after m0 drops its request; each receives only its own data.
- Both masters request continuously with MAX_HOLD=4 -> grant pattern is m0 x4, m1 x4, repeating; no cycle has both waitrequest=0 while both are requesting.
- Byte write, byteenable 0x2 with data 0x0000AB00 to a word holding 0x11223344 -> readback 0x1122AB44.
- Assert reset_n=0 in the cycle after a read is accepted -> no readdatavalid on either master; after reset release, state is IDLE and m0 wins the next tie.
- With CORE_RAM_ARB_LOCK_EN defined, m1 holds lock for 10 transfers while m0 requests -> m0_waitrequest=1 for all 10; m0 is granted the cycle after m1_lock drops.
